// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
// Holds the default result widths, the default source count and the
// cdb_entry record {tag, data, rs} that sources hand to the bus.
// Optional build macro used by this block: CDB_BYPASS_EN.
package cdb_arbiter_pkg;

  localparam int unsigned NumSrcDefault = 3;
  localparam int unsigned TagWidth      = 4;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned AluRsWidth    = 4;

  // One broadcast result. Buffers store it flattened in this field order.
  typedef struct packed {
    logic [TagWidth-1:0]   tag;
    logic [DataWidth-1:0]  data;
    logic [AluRsWidth-1:0] rs;
  } cdb_entry_t;

  localparam int unsigned CdbEntryWidth = $bits(cdb_entry_t);

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer for the CDB arbiter.
// Ports:
//   clk, rst (async active-low), flush (sync, empties buffer, drops push/pop)
//   push/wdata : write one entry (caller guarantees !full)
//   pop/rdata  : rdata is the head; pop drops it (caller guarantees !empty)
//   full/empty : occupancy flags
module cdb_src_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus stage: buffers results from NUM_SRC producers in per-source
// FIFOs and broadcasts one per cycle, chosen round-robin among non-empty
// buffers. cdb_rs returns the RS slot to free in source cdb_src.
// Ports:
//   clk, rst (async active-low), flush (sync, empties all buffers)
//   src_valid/src_ready, src_tag/src_data/src_rs : packed per-source inputs
//   cdb_valid, cdb_src, cdb_tag, cdb_data, cdb_rs : registered broadcast
// Optional macro CDB_BYPASS_EN: when every buffer is empty, arbitrate directly
// on src_valid and register the winner without buffering it.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC    = NumSrcDefault,
  parameter int unsigned TAG_W      = TagWidth,
  parameter int unsigned DATA_W     = DataWidth,
  parameter int unsigned RS_W       = AluRsWidth,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*RS_W-1:0]   src_rs,
  output logic                      cdb_valid,
  output logic [SRC_W-1:0]          cdb_src,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [RS_W-1:0]           cdb_rs
);

  localparam int unsigned EntryW = TAG_W + DATA_W + RS_W;

  logic [EntryW-1:0]  in_entry   [NUM_SRC];
  logic [EntryW-1:0]  head_entry [NUM_SRC];
  logic [EntryW-1:0]  win_entry;
  logic [NUM_SRC-1:0] fifo_full, fifo_empty;
  logic [NUM_SRC-1:0] push, pop, req, req_sh, gnt_onehot;
  logic               gnt_valid, bypass;
  logic [SRC_W-1:0]   gnt_idx, ptr_q, ptr_next;
  int unsigned        idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign in_entry[i] = {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W],
                          src_rs[i*RS_W +: RS_W]};

    cdb_src_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (EntryW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (in_entry[i]),
      .rdata (head_entry[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
  end

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign src_ready = ~fifo_full;

`ifdef CDB_BYPASS_EN
  assign bypass = (&fifo_empty) && (|src_valid);
`else
  assign bypass = 1'b0;
`endif

  assign req = bypass ? src_valid : ~fifo_empty;

  // Round-robin: first requester at ptr, ptr+1, ... modulo NUM_SRC.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    req_sh    = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx    = (32'(ptr_q) + k) % NUM_SRC;
      req_sh = req >> idx;
      if (!gnt_valid && req_sh[0]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(idx);
      end
    end
  end

  assign gnt_onehot = gnt_valid ? (NUM_SRC'(1) << gnt_idx) : '0;
  assign ptr_next   = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

  // A bypassed winner goes straight to the bus, so it must not be buffered.
  assign pop       = bypass ? '0 : gnt_onehot;
  assign push      = src_valid & src_ready & (bypass ? ~gnt_onehot : '1);
  assign win_entry = bypass ? in_entry[gnt_idx] : head_entry[gnt_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      cdb_valid <= 1'b0;
      cdb_src   <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_rs    <= '0;
    end else if (flush) begin
      ptr_q     <= '0;
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= gnt_valid;
      if (gnt_valid) begin
        ptr_q    <= ptr_next;
        cdb_src  <= gnt_idx;
        cdb_tag  <= win_entry[EntryW-1 -: TAG_W];
        cdb_data <= win_entry[RS_W +: DATA_W];
        cdb_rs   <= win_entry[RS_W-1:0];
      end
    end
  end

endmodule
